// File: rtl/zeroriscy_ex_seq_pkg.sv
// Shared definitions for the execute-stage sequencer: FSM state encoding,
// the timeout fill value and a width helper for unit index registers.
package zeroriscy_ex_seq_pkg;

   typedef enum logic [1:0] {
      EX_IDLE,
      EX_BUSY,
      EX_HOLD
   } ex_seq_state_e;

   // Replicated across the full result width when an operation times out.
   localparam logic EX_TIMEOUT_RESULT = 1'b1;

   function automatic int ex_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zeroriscy_ex_seq_prio_enc.sv
// Combinational priority encoder: lowest set index wins, plus any-set and
// more-than-one-set flags used for issue and one-hot checking.
module zeroriscy_ex_prio_enc
   import zeroriscy_ex_seq_pkg::*;
#(
   parameter int NUM_UNITS = 3
) (
   input  logic [NUM_UNITS-1:0]           en_i,
   output logic [ex_idx_w(NUM_UNITS)-1:0] idx_o,
   output logic                           any_o,
   output logic                           multi_o
);

   localparam int IDX_W = ex_idx_w(NUM_UNITS);

   always_comb begin
      idx_o = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (en_i[i]) idx_o = IDX_W'(i);
      end
   end

   assign any_o   = |en_i;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_o = |(en_i & (en_i - NUM_UNITS'(1)));

endmodule

// File: rtl/zeroriscy_ex_seq.sv
// Execute-stage sequencer for NUM_UNITS multi-cycle units with result holding,
// one-hot/timeout error pulses and flush. Optional counters: ZERORISCY_EX_PERF_EN.
module zeroriscy_ex_seq
   import zeroriscy_ex_seq_pkg::*;
#(
   parameter int NUM_UNITS      = 3,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_UNITS-1:0]          unit_en_i,
   input  logic [DATA_W-1:0]             alu_result_i,
   input  logic [NUM_UNITS*DATA_W-1:0]   unit_result_i,
   input  logic [NUM_UNITS-1:0]          unit_ready_i,
   input  logic                          flush_i,
   input  logic                          wb_ready_i,
   output logic [NUM_UNITS-1:0]          unit_start_o,
   output logic [DATA_W-1:0]             regfile_wdata_ex_o,
   output logic                          ex_ready_o,
   output logic                          ex_busy_o,
   output logic                          err_onehot_o,
   output logic                          err_timeout_o
`ifdef ZERORISCY_EX_PERF_EN
   ,
   output logic [NUM_UNITS*32-1:0]       perf_busy_cnt_o,
   output logic [31:0]                   perf_stall_cnt_o
`endif
);

   localparam int IDX_W = ex_idx_w(NUM_UNITS);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   ex_seq_state_e          state_q, state_d;
   logic [DATA_W-1:0]      hold_q, hold_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       sel_q, sel_d;
   logic [NUM_UNITS-1:0]   en_q, en_d;

   logic [IDX_W-1:0]       enc_idx;
   logic                   enc_any;
   logic                   enc_multi;
   logic                   sel_ready;
   logic [DATA_W-1:0]      sel_result;
   logic                   timeout_hit;

   zeroriscy_ex_prio_enc #(
      .NUM_UNITS (NUM_UNITS)
   ) u_prio_enc (
      .en_i    (unit_en_i),
      .idx_o   (enc_idx),
      .any_o   (enc_any),
      .multi_o (enc_multi)
   );

   assign sel_ready   = unit_ready_i[sel_q];
   assign sel_result  = unit_result_i[int'(sel_q)*DATA_W +: DATA_W];
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d            = state_q;
      hold_d             = hold_q;
      cnt_d              = cnt_q;
      sel_d              = sel_q;
      en_d               = en_q;
      unit_start_o       = '0;
      regfile_wdata_ex_o = hold_q;
      ex_ready_o         = 1'b0;
      err_onehot_o       = 1'b0;
      err_timeout_o      = 1'b0;

      case (state_q)
         EX_IDLE: begin
            regfile_wdata_ex_o = alu_result_i;
            if (flush_i) begin
               state_d = EX_IDLE;
            end else if (!enc_any) begin
               ex_ready_o = wb_ready_i;
            end else begin
               unit_start_o[enc_idx] = 1'b1;
               sel_d        = enc_idx;
               en_d         = unit_en_i;
               cnt_d        = '0;
               err_onehot_o = enc_multi;
               state_d      = EX_BUSY;
            end
         end

         EX_BUSY: begin
            cnt_d = sat_inc_cnt(cnt_q);
            if (flush_i) begin
               state_d = EX_IDLE;
            end else if (sel_ready || timeout_hit) begin
               // A real completion always beats the timeout in the same cycle.
               hold_d             = sel_ready ? sel_result : {DATA_W{EX_TIMEOUT_RESULT}};
               err_timeout_o      = !sel_ready;
               regfile_wdata_ex_o = hold_d;
               if (wb_ready_i) begin
                  ex_ready_o = 1'b1;
                  state_d    = EX_IDLE;
               end else begin
                  state_d    = EX_HOLD;
               end
            end
         end

         EX_HOLD: begin
            if (flush_i) begin
               state_d = EX_IDLE;
            end else begin
               ex_ready_o = wb_ready_i;
               if (wb_ready_i) state_d = EX_IDLE;
            end
         end

         default: state_d = EX_IDLE;
      endcase

      if (rst) begin
         unit_start_o  = '0;
         ex_ready_o    = 1'b0;
         err_onehot_o  = 1'b0;
         err_timeout_o = 1'b0;
      end
   end

   assign ex_busy_o = (state_q == EX_BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EX_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
      end
   end

`ifdef ZERORISCY_EX_PERF_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   logic [31:0] busy_cnt_q [NUM_UNITS];
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_UNITS; i++) busy_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q != EX_IDLE) busy_cnt_q[sel_q] <= sat_inc32(busy_cnt_q[sel_q]);
         if (state_q == EX_HOLD) stall_cnt_q <= sat_inc32(stall_cnt_q);
      end
   end

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_perf
      assign perf_busy_cnt_o[g*32 +: 32] = busy_cnt_q[g];
   end
   assign perf_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
   // ID must hold its enables steady until the operation completes or is flushed.
   a_en_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q != EX_IDLE && !flush_i) |-> (unit_en_i == en_q))
      else $error("unit_en_i changed while an operation was in flight");
`endif

endmodule

// File: tb/tb_zeroriscy_ex_seq.sv
// Scoreboard bench for zeroriscy_ex_seq: expected write-back values are queued
// at issue and checked whenever ex_ready_o is seen.
module tb_zeroriscy_ex_seq;

   localparam int NU = 3;
   localparam int DW = 32;
   localparam int TO = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NU-1:0]      unit_en;
   logic [DW-1:0]      alu_result;
   logic [NU*DW-1:0]   unit_result;
   logic [NU-1:0]      unit_ready;
   logic               flush;
   logic               wb_ready;
   logic [NU-1:0]      unit_start;
   logic [DW-1:0]      wdata;
   logic               ex_ready;
   logic               ex_busy;
   logic               err_onehot;
   logic               err_timeout;
`ifdef ZERORISCY_EX_PERF_EN
   logic [NU*32-1:0]   perf_busy_cnt;
   logic [31:0]        perf_stall_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   zeroriscy_ex_seq #(
      .NUM_UNITS      (NU),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .unit_en_i          (unit_en),
      .alu_result_i       (alu_result),
      .unit_result_i      (unit_result),
      .unit_ready_i       (unit_ready),
      .flush_i            (flush),
      .wb_ready_i         (wb_ready),
      .unit_start_o       (unit_start),
      .regfile_wdata_ex_o (wdata),
      .ex_ready_o         (ex_ready),
      .ex_busy_o          (ex_busy),
      .err_onehot_o       (err_onehot),
      .err_timeout_o      (err_timeout)
`ifdef ZERORISCY_EX_PERF_EN
      ,
      .perf_busy_cnt_o    (perf_busy_cnt),
      .perf_stall_cnt_o   (perf_stall_cnt)
`endif
   );

   // Every accepted result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && ex_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: ex_ready_o=1 wdata=%h, no result expected", wdata);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (wdata !== e) begin
               miscompares++;
               $display("FAIL sb_wdata: got %h want %h", wdata, e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      unit_en    = '0;
      unit_ready = '0;
      flush      = 1'b0;
      wb_ready   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs(); alu_result = 32'h0; unit_result = '0;
      cyc(); cyc();
      unit_en = 3'b001; wb_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (unit_start !== 3'b000 || ex_ready !== 1'b0 || ex_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: start=%b ready=%b busy=%b want 000/0/0", unit_start, ex_ready, ex_busy);
      end
      cyc(); idle_inputs(); rst = 1'b0;
      cyc();
   endtask

   task automatic test_alu();
      cyc(); unit_en = '0; wb_ready = 1'b1; alu_result = 32'h1234; exp_q.push_back(32'h1234);
      @(negedge clk);
      vectors++;
      if (ex_ready !== 1'b1 || unit_start !== 3'b000) begin
         miscompares++;
         $display("FAIL alu_ready: ready=%b start=%b want 1/000", ex_ready, unit_start);
      end
      cyc(); alu_result = 32'hCAFE_0001; exp_q.push_back(32'hCAFE_0001);
      cyc(); wb_ready = 1'b0; alu_result = 32'h5555;
      @(negedge clk);
      vectors++;
      if (ex_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_wb_stall: ready=%b want 0", ex_ready);
      end
   endtask

   task automatic test_unit(input int unit, input int lat, input logic [DW-1:0] res, input int hold_cycles);
      logic [NU-1:0] oh;
      oh = 3'b001 << unit;
      cyc(); unit_en = oh; unit_result[unit*DW +: DW] = res; wb_ready = 1'b1; unit_ready = '0;
      exp_q.push_back(res);
      @(negedge clk);
      vectors++;
      if (unit_start !== oh || ex_ready !== 1'b0 || err_onehot !== 1'b0) begin
         miscompares++;
         $display("FAIL unit%0d_issue: start=%b ready=%b err=%b want %b/0/0", unit, unit_start, ex_ready, err_onehot, oh);
      end
      for (int i = 1; i <= lat; i++) begin
         cyc();
         unit_ready = (i == lat) ? oh : '0;
         wb_ready   = (i == lat && hold_cycles > 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         vectors++;
         if (unit_start !== 3'b000 || ex_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL unit%0d_busy_c%0d: start=%b busy=%b want 000/1", unit, i, unit_start, ex_busy);
         end
         vectors++;
         if (ex_ready !== (i == lat && hold_cycles == 0)) begin
            miscompares++;
            $display("FAIL unit%0d_ready_c%0d: ready=%b want %b", unit, i, ex_ready, (i == lat && hold_cycles == 0));
         end
      end
      for (int h = 1; h <= hold_cycles; h++) begin
         cyc(); unit_ready = '0; wb_ready = 1'b0; unit_result[unit*DW +: DW] = ~res;
         @(negedge clk);
         vectors++;
         if (ex_ready !== 1'b0 || wdata !== res || ex_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL unit%0d_hold_c%0d: ready=%b wdata=%h busy=%b want 0/%h/0", unit, h, ex_ready, wdata, ex_busy, res);
         end
      end
      if (hold_cycles > 0) begin
         cyc(); wb_ready = 1'b1;
         @(negedge clk);
         vectors++;
         if (ex_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL unit%0d_hold_release: ready=%b want 1", unit, ex_ready);
         end
      end
      cyc(); idle_inputs();
      @(negedge clk);
      vectors++;
      if (ex_busy !== 1'b0 || unit_start !== 3'b000 || ex_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL unit%0d_back_idle: busy=%b start=%b ready=%b want 0/000/0", unit, ex_busy, unit_start, ex_ready);
      end
   endtask

   task automatic test_onehot();
      int pulses;
      pulses = 0;
      cyc(); unit_en = 3'b110; wb_ready = 1'b1;
      unit_result[1*DW +: DW] = 32'h1111_2222; unit_result[2*DW +: DW] = 32'h9999_9999;
      exp_q.push_back(32'h1111_2222);
      @(negedge clk);
      if (err_onehot === 1'b1) pulses++;
      vectors++;
      if (unit_start !== 3'b010) begin
         miscompares++;
         $display("FAIL onehot_start: start=%b want 010", unit_start);
      end
      cyc(); unit_ready = 3'b100;
      @(negedge clk);
      if (err_onehot === 1'b1) pulses++;
      vectors++;
      if (ex_ready !== 1'b0 || ex_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL onehot_other_ready: ready=%b busy=%b want 0/1", ex_ready, ex_busy);
      end
      cyc(); unit_ready = 3'b010;
      @(negedge clk);
      if (err_onehot === 1'b1) pulses++;
      vectors++;
      if (ex_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL onehot_done: ready=%b want 1", ex_ready);
      end
      cyc(); idle_inputs();
      @(negedge clk);
      if (err_onehot === 1'b1) pulses++;
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL onehot_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_timeout();
      cyc(); unit_en = 3'b001; wb_ready = 1'b1; exp_q.push_back(32'hFFFF_FFFF);
      for (int i = 1; i <= TO; i++) begin
         cyc();
         @(negedge clk);
         vectors++;
         if (err_timeout !== (i == TO) || ex_ready !== (i == TO)) begin
            miscompares++;
            $display("FAIL timeout_c%0d: err=%b ready=%b want %b/%b", i, err_timeout, ex_ready, (i == TO), (i == TO));
         end
      end
      cyc(); idle_inputs();
      @(negedge clk);
      vectors++;
      if (err_timeout !== 1'b0 || ex_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_after: err=%b busy=%b want 0/0", err_timeout, ex_busy);
      end
   endtask

   task automatic test_back_to_back();
      cyc(); unit_en = 3'b001; wb_ready = 1'b1; unit_result[0 +: DW] = 32'hA0A0_0001;
      exp_q.push_back(32'hA0A0_0001);
      cyc(); unit_ready = 3'b001;
      @(negedge clk);
      vectors++;
      if (ex_ready !== 1'b1 || unit_start !== 3'b000) begin
         miscompares++;
         $display("FAIL b2b_complete: ready=%b start=%b want 1/000", ex_ready, unit_start);
      end
      cyc(); unit_ready = '0; unit_en = 3'b100; unit_result[2*DW +: DW] = 32'hB0B0_0002;
      exp_q.push_back(32'hB0B0_0002);
      @(negedge clk);
      vectors++;
      if (unit_start !== 3'b100) begin
         miscompares++;
         $display("FAIL b2b_second_start: start=%b want 100", unit_start);
      end
      cyc(); cyc(); unit_ready = 3'b100;
      cyc(); idle_inputs();
   endtask

   task automatic test_flush_reset();
      cyc(); unit_en = 3'b100; wb_ready = 1'b1; unit_result[2*DW +: DW] = 32'hBAD0_BAD0;
      cyc();
      cyc(); flush = 1'b1; unit_ready = 3'b100;
      @(negedge clk);
      vectors++;
      if (ex_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_busy: ready=%b want 0", ex_ready);
      end
      cyc(); idle_inputs();
      @(negedge clk);
      vectors++;
      if (ex_busy !== 1'b0 || ex_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_idle: busy=%b ready=%b want 0/0", ex_busy, ex_ready);
      end
      cyc(); unit_en = 3'b001; flush = 1'b1;
      @(negedge clk);
      vectors++;
      if (unit_start !== 3'b000) begin
         miscompares++;
         $display("FAIL flush_issue: start=%b want 000", unit_start);
      end
      cyc(); flush = 1'b0; unit_en = 3'b000;
      @(negedge clk);
      vectors++;
      if (ex_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_issue_idle: busy=%b want 0", ex_busy);
      end
      cyc(); unit_en = 3'b001; unit_result[0 +: DW] = 32'h7777_7777;
      cyc(); unit_ready = 3'b001; wb_ready = 1'b0;
      cyc(); unit_ready = '0;
      cyc(); rst = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (ex_ready !== 1'b0 || unit_start !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_hold: ready=%b start=%b want 0/000", ex_ready, unit_start);
      end
      cyc(); rst = 1'b0; idle_inputs(); alu_result = 32'h0BAD_F00D;
      @(negedge clk);
      vectors++;
      if (ex_busy !== 1'b0 || wdata !== 32'h0BAD_F00D || err_onehot !== 1'b0 || err_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_idle: busy=%b wdata=%h errs=%b%b want 0/0badf00d/00", ex_busy, wdata, err_onehot, err_timeout);
      end
      cyc(); wb_ready = 1'b1; exp_q.push_back(32'h0BAD_F00D);
      cyc(); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_unit(1, 5, 32'hDEAD_BEEF, 0);
      test_unit(1, 5, 32'hDEAD_BEEF, 3);
      test_unit(2, 1, 32'h0102_0304, 0);
      test_onehot();
      test_timeout();
      test_back_to_back();
      test_flush_reset();
      cyc(); cyc();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: %0d results never presented, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
